// File: rtl/bisg_test_sequencer.sv
// BISG test-session sequencer: sweeps the range code, launches one scan run per code
// and accumulates pass/fail. Optional run timeout via BISG_SEQ_RUN_TIMEOUT_EN.
module bisg_test_sequencer #(
  parameter int SIG_W      = 13,
  parameter int RST_CYC    = 8,
  parameter int LOCK_TO    = 1023,
  parameter int RUN_MARGIN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             adpll_lock,
  input  logic [5:0]       range_lo,
  input  logic [5:0]       range_hi,
  input  logic [19:0]      scan_num,
  input  logic [SIG_W-1:0] golden,
  input  logic [SIG_W-1:0] sig_in,
  input  logic             scan_done_in,
  output logic             sub_rst,
  output logic             test_se,
  output logic             bisg_start,
  output logic [5:0]       range_out,
  output logic             busy,
  output logic             done,
  output logic             pass_all,
  output logic [6:0]       fail_cnt,
  output logic [5:0]       first_fail,
  output logic             lock_err,
  output logic             timeout_err
);
  localparam int LC_W = $clog2(LOCK_TO + 1);
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOCK, S_RESET, S_LAUNCH, S_RUN, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [19:0]       run_cnt_q, run_cnt_d, run_inc;
  logic [5:0]        range_q, range_d, first_fail_q, first_fail_d;
  logic [6:0]        fail_cnt_q, fail_cnt_d;
  logic              lock_err_q, lock_err_d, pass_all_q, pass_all_d;
  logic              sub_rst_q, test_se_q, bisg_start_q, busy_q, done_q;
  logic              rec_fail, tmo_hit;

  assign run_inc = (run_cnt_q == 20'hFFFFF) ? run_cnt_q : run_cnt_q + 20'd1;

`ifdef BISG_SEQ_RUN_TIMEOUT_EN
  logic        timeout_err_q, timeout_err_d;
  logic [20:0] run_lim;
  assign run_lim     = {1'b0, scan_num} + 21'(RUN_MARGIN);
  assign tmo_hit     = ({1'b0, run_inc} >= run_lim);
  assign timeout_err = timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    run_cnt_d    = run_cnt_q;
    range_d      = range_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    lock_err_d   = lock_err_q;
    pass_all_d   = pass_all_q;
    rec_fail     = 1'b0;
`ifdef BISG_SEQ_RUN_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
`endif
    if (abort) begin
      state_d    = S_IDLE;
      pass_all_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          fail_cnt_d   = '0;
          first_fail_d = '0;
          lock_err_d   = 1'b0;
          pass_all_d   = 1'b0;
          range_d      = range_lo;
          lock_cnt_d   = '0;
`ifdef BISG_SEQ_RUN_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
          state_d = (range_lo > range_hi) ? S_DONE : S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (adpll_lock) begin
            rst_cnt_d = '0;
            state_d   = S_RESET;
          end else if (lock_cnt_q == LC_W'(LOCK_TO)) begin
            lock_err_d = 1'b1;
            rec_fail   = 1'b1;
            state_d    = S_NEXT;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        S_RESET: begin
          if (rst_cnt_q == RC_W'(RST_CYC - 1)) state_d = S_LAUNCH;
          else rst_cnt_d = rst_cnt_q + 1'b1;
        end
        S_LAUNCH: begin
          run_cnt_d = '0;
          state_d   = S_RUN;
        end
        S_RUN: begin
          run_cnt_d = run_inc;
          // scan_done wins over a same-cycle lock drop
          if (scan_done_in) begin
            state_d = S_CHECK;
          end else if (!adpll_lock) begin
            rec_fail = 1'b1;
            state_d  = S_NEXT;
          end else if (tmo_hit) begin
`ifdef BISG_SEQ_RUN_TIMEOUT_EN
            timeout_err_d = 1'b1;
`endif
            rec_fail = 1'b1;
            state_d  = S_NEXT;
          end
        end
        S_CHECK: begin
          rec_fail = !((sig_in == golden) && (run_cnt_q == scan_num));
          state_d  = S_NEXT;
        end
        S_NEXT: begin
          if (range_q == range_hi || range_q == 6'd63) begin
            pass_all_d = (fail_cnt_q == 7'd0) && (range_lo <= range_hi);
            state_d    = S_DONE;
          end else begin
            range_d    = range_q + 6'd1;
            lock_cnt_d = '0;
            state_d    = S_WAIT_LOCK;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (rec_fail) begin
        if (fail_cnt_q == 7'd0) first_fail_d = range_q;
        if (fail_cnt_q != 7'h7F) fail_cnt_d = fail_cnt_q + 7'd1;
      end
    end
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lock_cnt_q   <= '0;
      rst_cnt_q    <= '0;
      run_cnt_q    <= '0;
      range_q      <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      lock_err_q   <= 1'b0;
      pass_all_q   <= 1'b0;
      sub_rst_q    <= 1'b0;
      test_se_q    <= 1'b0;
      bisg_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      run_cnt_q    <= run_cnt_d;
      range_q      <= range_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      lock_err_q   <= lock_err_d;
      pass_all_q   <= pass_all_d;
      sub_rst_q    <= (state_d == S_RESET);
      test_se_q    <= (state_d == S_LAUNCH) || (state_d == S_RUN);
      bisg_start_q <= (state_d == S_LAUNCH);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  end

`ifdef BISG_SEQ_RUN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_err_q <= 1'b0;
    else        timeout_err_q <= timeout_err_d;
  end
`endif

  assign sub_rst    = sub_rst_q;
  assign test_se    = test_se_q;
  assign bisg_start = bisg_start_q;
  assign range_out  = range_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_all   = pass_all_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;
  assign lock_err   = lock_err_q;
endmodule

// File: tb/tb_bisg_test_sequencer.sv
// Scoreboard bench for bisg_test_sequencer: a small BISG/ADPLL model reacts to the
// sequencer, expected launches and sweep results are queued and checked on output.
module tb_bisg_test_sequencer;
  localparam int SIG_W = 13, RST_CYC = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic adpll_lock = 1'b0, scan_done_in = 1'b0;
  logic [5:0] range_lo = '0, range_hi = '0;
  logic [19:0] scan_num = 20'd100;
  logic [SIG_W-1:0] golden = 13'h1ABC, sig_in = '0;
  logic sub_rst, test_se, bisg_start, busy, done, pass_all, lock_err, timeout_err;
  logic [5:0] range_out, first_fail;
  logic [6:0] fail_cnt;

  bisg_test_sequencer #(.SIG_W(SIG_W), .RST_CYC(RST_CYC), .LOCK_TO(1023), .RUN_MARGIN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .adpll_lock(adpll_lock),
    .range_lo(range_lo), .range_hi(range_hi), .scan_num(scan_num), .golden(golden),
    .sig_in(sig_in), .scan_done_in(scan_done_in), .sub_rst(sub_rst), .test_se(test_se),
    .bisg_start(bisg_start), .range_out(range_out), .busy(busy), .done(done),
    .pass_all(pass_all), .fail_cnt(fail_cnt), .first_fail(first_fail),
    .lock_err(lock_err), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  typedef struct packed { logic pass; logic [6:0] fc; logic [5:0] ff; logic le; } res_t;
  res_t exp_res[$];
  int   exp_rng[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_seen = 0;
  bit chk_lat = 0, sub_rst_seen = 0;

  // model knobs
  bit lock_en = 0, done_en = 1, drop_en = 0;
  int done_at = 100, bad_code = -1, drop_code = -1, m_cnt = 0;
  logic [SIG_W-1:0] good_sig = 13'h1ABC, bad_sig = 13'h1ABD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // BISG / ADPLL model, driven away from the active edge
  always @(negedge clk) begin
    if (bisg_start) m_cnt = 0;
    else if (test_se) m_cnt = m_cnt + 1;
    scan_done_in = test_se && !bisg_start && done_en && (m_cnt == done_at);
    sig_in       = (int'(range_out) == bad_code) ? bad_sig : good_sig;
    adpll_lock   = lock_en && !(drop_en && test_se && int'(range_out) == drop_code && m_cnt >= 50);
  end

  // output monitor: pop expectations as the DUT produces them
  always @(negedge clk) begin
    if (sub_rst) sub_rst_seen = 1;
    if (bisg_start) begin
      if (exp_rng.size() == 0) chk("launch_unexp", range_out, 6'h3F);
      else chk("launch_rng", range_out, exp_rng.pop_front());
      if (chk_lat) begin
        chk("launch_lat", cyc - start_cyc, 2 + RST_CYC);
        chk_lat = 0;
      end
    end
    if (done) begin
      res_t e;
      done_seen++;
      done_cyc = cyc;
      if (exp_res.size() == 0) chk("done_unexp", 1, 0);
      else begin
        e = exp_res.pop_front();
        chk("pass_all", pass_all, e.pass);
        chk("fail_cnt", fail_cnt, e.fc);
        chk("first_fail", first_fail, e.ff);
        chk("lock_err", lock_err, e.le);
      end
    end
  end

  task automatic do_start(input logic [5:0] lo, input logic [5:0] hi);
    @(posedge clk); #1;
    range_lo = lo; range_hi = hi; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic sweep(input logic [5:0] lo, input logic [5:0] hi, input res_t r, input int maxc);
    int d0;
    d0 = done_seen;
    if (lo <= hi) for (int c = lo; c <= hi; c++) exp_rng.push_back(c);
    exp_res.push_back(r);
    do_start(lo, hi);
    wait_idle(maxc);
    @(posedge clk); #1;
    chk("done_cnt", done_seen - d0, 1);
    chk("launch_left", exp_rng.size(), 0);
    chk("res_left", exp_res.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {sub_rst, test_se, bisg_start, range_out, busy, done, pass_all,
                       fail_cnt, first_fail, lock_err, timeout_err}, 0);
    rst_n = 1'b1;
    lock_en = 1;
    repeat (2) @(posedge clk);

    // full pass, with start-to-busy and launch latency checks
    chk_lat = 1;
    exp_rng.push_back(3); exp_rng.push_back(4); exp_rng.push_back(5);
    exp_res.push_back('{pass: 1'b1, fc: 7'd0, ff: 6'd0, le: 1'b0});
    d0 = done_seen;
    do_start(6'd3, 6'd5);
    chk("busy_c1", busy, 1);
    wait_idle(2000);
    repeat (3) @(posedge clk);
    #1;
    chk("done_cnt", done_seen - d0, 1);
    chk("pass_hold", pass_all, 1);
    chk("launch_left", exp_rng.size(), 0);

    // signature miss on code 4
    bad_code = 4;
    sweep(6'd3, 6'd5, '{pass: 1'b0, fc: 7'd1, ff: 6'd4, le: 1'b0}, 2000);
    bad_code = -1;

    // lock timeout, no lock at all
    lock_en = 0; sub_rst_seen = 0;
    exp_res.push_back('{pass: 1'b0, fc: 7'd1, ff: 6'd7, le: 1'b1});
    d0 = done_seen;
    do_start(6'd7, 6'd7);
    wait_idle(1500);
    chk("lock_done_lat", done_cyc - start_cyc, 1026);
    chk("lock_done_cnt", done_seen - d0, 1);
    chk("sub_rst_seen", sub_rst_seen, 0);
    lock_en = 1;

    // scan count one short
    done_at = 99;
    sweep(6'd2, 6'd2, '{pass: 1'b0, fc: 7'd1, ff: 6'd2, le: 1'b0}, 1000);
    done_at = 100;

    // lock drop mid-RUN on code 10, code 11 passes
    drop_en = 1; drop_code = 10;
    sweep(6'd10, 6'd11, '{pass: 1'b0, fc: 7'd1, ff: 6'd10, le: 1'b0}, 1000);
    drop_en = 0; drop_code = -1;
    chk("timeout_err_nodrop", timeout_err, 0);

    // abort mid-RUN; start must first clear the previous fail count
    exp_rng.push_back(3);
    d0 = done_seen;
    do_start(6'd3, 6'd5);
    chk("start_clears", fail_cnt, 0);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (test_se && !bisg_start && m_cnt == 50) break;
    end
    chk("abort_reach", m_cnt, 50);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_se", test_se, 0);
    chk("abort_pass", pass_all, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_nodone", done_seen - d0, 0);
    chk("abort_launch_left", exp_rng.size(), 0);

    // empty sweep: lo > hi
    sweep(6'd9, 6'd8, '{pass: 1'b0, fc: 7'd0, ff: 6'd0, le: 1'b0}, 100);

    // top boundary, no wrap past 63
    sweep(6'd62, 6'd63, '{pass: 1'b1, fc: 7'd0, ff: 6'd0, le: 1'b0}, 1000);
    chk("top_range", range_out, 63);

    // BISG never reports scan_done
    done_en = 0;
`ifdef BISG_SEQ_RUN_TIMEOUT_EN
    sweep(6'd1, 6'd1, '{pass: 1'b0, fc: 7'd1, ff: 6'd1, le: 1'b0}, 1000);
    chk("timeout_err", timeout_err, 1);
`else
    exp_rng.push_back(1);
    d0 = done_seen;
    do_start(6'd1, 6'd1);
    repeat (300) @(posedge clk);
    #1;
    chk("run_hang_busy", busy, 1);
    chk("run_hang_se", test_se, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("hang_abort_busy", busy, 0);
    chk("hang_timeout_err", timeout_err, 0);
    chk("hang_nodone", done_seen - d0, 0);
`endif
    done_en = 1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bisg_test_sequencer.md
# bisg_test_sequencer

Test-session controller for the BISG self-convergence datapath. It walks the `range` code from a programmable low to high bound. For each code it waits for ADPLL lock, pulses the sub-block reset, launches one scan run with `test_se` held, and waits for `scan_done`. It then compares the returned signature and the scan-cycle count against golden values. Per-sweep pass/fail results are accumulated for the testbench or scan readout and sit between the test harness and the BISG top.

## Interface
Parameters:
- `SIG_W`, 13, signature width (matches BISG `sigLength`)
- `RST_CYC`, 8, `sub_rst` pulse length in cycles (≥1)
- `LOCK_TO`, 1023, maximum cycles to wait for `adpll_lock` per range code
- `RUN_MARGIN`, 16, extra cycles beyond `scan_num` before run timeout (used only with the macro)

Ports:
- `clk`  in  1  single system clock
- `rst_n`  in  1  reset; **asynchronous, active-low**
- `start`  in  1  one-cycle request; accepted only in IDLE
- `abort`  in  1  synchronous abort; returns the block to IDLE from any state
- `adpll_lock`  in  1  ADPLL lock indicator
- `range_lo`, `range_hi`  in  6  inclusive sweep bounds
- `scan_num`  in  20  expected scan cycles per run
- `golden`  in  SIG_W  expected signature
- `sig_in`  in  SIG_W  signature from BISG
- `scan_done_in`  in  1  run-complete from BISG
- `sub_rst`  out  1  BISG sub-block reset, active-high
- `test_se`  out  1  scan enable
- `bisg_start`  out  1  one-cycle launch pulse
- `range_out`  out  6  current range code
- `busy`  out  1  high in any non-IDLE state
- `done`  out  1  one-cycle sweep-complete pulse
- `pass_all`  out  1  every code in the sweep passed
- `fail_cnt`  out  7  number of failing codes
- `first_fail`  out  6  first failing code; valid when `fail_cnt` is non-zero
- `lock_err`  out  1  lock timeout occurred (sticky per sweep)
- `timeout_err`  out  1  run timeout occurred (sticky); tied 0 without the macro

## Operation
- States: IDLE, WAIT_LOCK, RESET, LAUNCH, RUN, CHECK, NEXT, DONE.
- **IDLE**
  - On `start`: clear results, load `range_out=range_lo`, go to WAIT_LOCK.
  - If `range_lo>range_hi`: go directly to DONE with `pass_all=0` and `fail_cnt=0`.
- **WAIT_LOCK**
  - Lock counter counts up.
  - `adpll_lock=1` → RESET.
  - Counter reaches `LOCK_TO` → set `lock_err`, record a fail for the current code, go to NEXT.
- **RESET**: `sub_rst=1` for exactly `RST_CYC` cycles, then LAUNCH.
- **LAUNCH**: `bisg_start=1` and `test_se=1` for one cycle; clear the 20-bit run counter; go to RUN.
- **RUN**
  - `test_se=1`; the run counter increments every cycle and saturates at 0xFFFFF.
  - `scan_done_in=1` → CHECK.
  - `adpll_lock` drops → record a fail, go to NEXT.
- **CHECK**: the code passes iff `sig_in==golden` and the run count equals `scan_num`. Otherwise record a fail.
- **Recording a fail**: `fail_cnt+1` (saturates at 127). `first_fail` is loaded only when `fail_cnt` was 0.
- **NEXT**
  - `range_out==range_hi` → DONE.
  - Otherwise `range_out+1` → WAIT_LOCK.
  - No wrap past 63: `range_hi=63` terminates at 63.
- **DONE**: `done=1` for one cycle; `pass_all=(fail_cnt==0 && range_lo<=range_hi)`; then IDLE.
- **Result hold**: results hold until the next accepted `start`.
- **abort**
  - Has priority over every transition; next state is IDLE.
  - `sub_rst`, `test_se` and `bisg_start` drop the following cycle.
  - `done` is not pulsed; partial results are kept; `pass_all=0`.
- `start` while busy is ignored.
- If `scan_done_in` and a lock drop occur in the same RUN cycle, `scan_done_in` wins and the block goes to CHECK.

## Timing
- All outputs are registered. Reset value of every output is 0, including `range_out=0`.
- `start` at cycle 0 → `busy=1` and WAIT_LOCK at cycle 1.
- With lock already high: RESET spans cycles 2..1+`RST_CYC`, and LAUNCH follows at cycle 2+`RST_CYC`.
- CHECK and NEXT take one cycle each. Per-code overhead excluding RUN = 4+`RST_CYC` cycles.
- Asserting `rst_n` mid-sweep forces IDLE and all outputs to 0 immediately, with no `done`.

## Configuration
- `BISG_SEQ_RUN_TIMEOUT_EN` defined:
  - In RUN, if the run counter reaches `scan_num+RUN_MARGIN` without `scan_done_in`, set `timeout_err`, record a fail, and go to NEXT.
- Undefined:
  - RUN waits indefinitely; only `abort` or `rst_n` exits.
  - `timeout_err` is constant 0 and the comparator is not built.

## Test plan
- **Full pass**: `range_lo=3`, `range_hi=5`, lock high, BISG returns `sig=0x1ABC`=`golden` after `scan_num=100` cycles → 3 `bisg_start` pulses with `range_out` 3,4,5; `done` once; `pass_all=1`; `fail_cnt=0`.
- **Signature miss**: same sweep, code 4 returns 0x1ABD → `fail_cnt=1`, `first_fail=4`, `pass_all=0`.
- **Lock timeout**: `adpll_lock=0` throughout, `LOCK_TO=1023`, `lo=hi=7` → `lock_err=1`, `fail_cnt=1`, `done` 1026 cycles after `start`, `sub_rst` never high.
- **Count mismatch and lock drop**:
  - `scan_done_in` at count 99 with `scan_num=100` → fail recorded.
  - Lock drop mid-RUN → fail recorded, advance to the next code.
- **Abort mid-RUN**: `abort` at RUN cycle 50 → IDLE next cycle; `test_se=0`; no `done`. A subsequent `start` clears the results.
- **Macro on, no scan_done**: `scan_num=100`, `RUN_MARGIN=16` → `timeout_err=1` after 116 RUN cycles. Macro off: `busy` stays high until `abort`.
